// File: rtl/uart_bench_host.sv
// uart_bench_host: hardware stand-in for the PC host of the PQC benchmark.
// Sends one 8N1 seed byte and then waits for the single reply byte. It reports
// the reply, the turnaround cycle count and the timeout and framing flags.
// DIV must be at least 4 so that the half-bit delay before the centre sample
// is never zero.

module uart_bench_host #(
    parameter int unsigned DIV     = 234,
    parameter logic [31:0] TIMEOUT = 32'd50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  seed,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        busy,
    output logic        done,
    output logic [7:0]  result,
    output logic [31:0] cycles,
    output logic        timeout_err,
    output logic        frame_err
);

    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 2;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((DIV / 2) - 1);
    localparam logic [3:0] TX_LAST_BIT = 4'd9;
    localparam logic [3:0] RX_LAST_BIT = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RX_START,
        S_RX_DATA,
        S_RX_STOP,
        S_FINISH
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_div_cnt;
    logic [3:0]        r_bit_cnt;
    logic [8:0]        r_tx_shift;
    logic [7:0]        r_rx_shift;
    logic              r_tx;
    logic              r_busy;
    logic              r_done;
    logic [7:0]        r_result;
    logic [31:0]       r_cycles;
    logic              r_timeout_err;
    logic              r_frame_err;
    logic              r_rx_s1;
    logic              r_rx_s2;
    logic              r_rx_prev;

    logic              w_rx;
    logic              w_rx_fall;
    logic [31:0]       w_cyc_inc;

    assign w_rx      = r_rx_s2;
    assign w_rx_fall = r_rx_prev & ~r_rx_s2;
    assign w_cyc_inc = (r_cycles == 32'hFFFF_FFFF) ? r_cycles : r_cycles + 32'd1;

    assign uart_tx     = r_tx;
    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign cycles      = r_cycles;
    assign timeout_err = r_timeout_err;
    assign frame_err   = r_frame_err;

    // Two-flop synchroniser for the asynchronous reply line, plus a delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= uart_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // Transaction FSM: transmit seed, time the turnaround, receive and report the reply
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_div_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_tx_shift    <= '1;
            r_rx_shift    <= '0;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= '0;
            r_cycles      <= '0;
            r_timeout_err <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Start bit goes out in the very next cycle; data bits and stop wait in the shifter
                        r_tx          <= 1'b0;
                        r_tx_shift    <= {1'b1, seed};
                        r_result      <= '0;
                        r_cycles      <= '0;
                        r_timeout_err <= 1'b0;
                        r_frame_err   <= 1'b0;
                        r_busy        <= 1'b1;
                        r_div_cnt     <= '0;
                        r_bit_cnt     <= '0;
                        r_state       <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (r_div_cnt == BIT_LAST) begin
                        r_div_cnt <= '0;
                        if (r_bit_cnt == TX_LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_WAIT;
                        end else begin
                            r_bit_cnt  <= r_bit_cnt + 4'd1;
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + CNT_W'(1);
                    end
                end

                S_WAIT: begin
                    // The edge cycle itself is not counted; the count freezes while the start bit is qualified
                    if (w_rx_fall) begin
                        r_div_cnt <= '0;
                        r_state   <= S_RX_START;
                    end else if (w_cyc_inc >= TIMEOUT) begin
                        r_cycles      <= w_cyc_inc;
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= S_FINISH;
                    end else begin
                        r_cycles <= w_cyc_inc;
                    end
                end

                S_RX_START: begin
                    // Re-check the line mid start bit; a high sample means the edge was a glitch
                    if (r_div_cnt == HALF_LAST) begin
                        r_div_cnt <= '0;
                        if (!w_rx) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_RX_DATA;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + CNT_W'(1);
                    end
                end

                S_RX_DATA: begin
                    if (r_div_cnt == BIT_LAST) begin
                        r_div_cnt  <= '0;
                        r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                        if (r_bit_cnt == RX_LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_RX_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + CNT_W'(1);
                    end
                end

                S_RX_STOP: begin
                    // Data is reported even when the stop bit is bad
                    if (r_div_cnt == BIT_LAST) begin
                        r_div_cnt   <= '0;
                        r_frame_err <= ~w_rx;
                        r_result    <= r_rx_shift;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_FINISH;
                    end else begin
                        r_div_cnt <= r_div_cnt + CNT_W'(1);
                    end
                end

                S_FINISH: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bench_host.sv
// tb_uart_bench_host: random transactions against a reference model of the host.
// The driver plays the DUT side of the link and queues the expected outcomes.
// Independent monitors decode uart_tx frames and check every done pulse.

module tb_uart_bench_host;

    localparam int unsigned DIV  = 4;
    localparam int unsigned HALF = DIV / 2;
    localparam logic [31:0] TOUT = 32'd500;

    localparam int M_NORMAL  = 0;
    localparam int M_TIMEOUT = 1;
    localparam int M_GLITCH  = 2;
    localparam int M_FRAME   = 3;

    typedef struct packed {
        logic [7:0]  res;
        logic [31:0] cyc;
        logic        to;
        logic        fe;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  seed;
    logic        uart_tx;
    logic        uart_rx;
    logic        busy;
    logic        done;
    logic [7:0]  result;
    logic [31:0] cycles;
    logic        timeout_err;
    logic        frame_err;

    exp_t        exp_q[$];
    logic [7:0]  tx_q[$];
    logic        tx_mon_en;
    int          n_checks;
    int          n_pass;

    uart_bench_host #(
        .DIV     (DIV),
        .TIMEOUT (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seed        (seed),
        .uart_tx     (uart_tx),
        .uart_rx     (uart_rx),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .cycles      (cycles),
        .timeout_err (timeout_err),
        .frame_err   (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] sd);
        seed  = sd;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 5000) begin
            tick(1);
            k++;
        end
        chk("busy_drops_within_bound", {31'b0, busy}, 32'd0);
        tick(1);
    endtask

    // Play the DUT's transmitter: start, 8 data bits LSB first, given stop level
    task automatic send_reply(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(DIV);
        end
        uart_rx = stop_bit;
        tick(DIV);
        uart_rx = 1'b1;
    endtask

    // One full transaction; d = reply delay after the end of our stop bit, g = glitch offset
    task automatic run_txn(input logic [7:0] sd, input int mode, input logic [7:0] reply,
                           input int d, input int g);
        exp_t e;
        e.res = (mode == M_TIMEOUT) ? 8'h00 : reply;
        e.to  = (mode == M_TIMEOUT);
        e.fe  = (mode == M_FRAME);
        // Two synchroniser cycles add to the delay; glitch qualification (edge + half bit) is excluded
        if (mode == M_TIMEOUT)     e.cyc = TOUT;
        else if (mode == M_GLITCH) e.cyc = 32'(d + 2 - (HALF + 1));
        else                       e.cyc = 32'(d + 2);
        exp_q.push_back(e);
        tx_q.push_back(sd);

        pulse_start(sd);
        chk("busy_after_accept", {31'b0, busy}, 32'd1);

        case (mode)
            M_NORMAL: begin
                tick(10 * DIV + 1);
                pulse_start(~sd);
                tick(d - 2);
                send_reply(reply, 1'b1);
            end
            M_GLITCH: begin
                tick(10 * DIV + g);
                uart_rx = 1'b0;
                tick(1);
                uart_rx = 1'b1;
                tick(d - g - 1);
                send_reply(reply, 1'b1);
            end
            M_FRAME: begin
                tick(10 * DIV + d);
                send_reply(reply, 1'b0);
            end
            default: begin
            end
        endcase
        wait_idle();
    endtask

    // Decode every frame on uart_tx, checking each bit holds for exactly DIV cycles
    initial begin
        logic [9:0] frame;
        logic [7:0] sd;
        logic       bad;
        forever begin
            @(negedge clk);
            if (tx_mon_en && uart_tx === 1'b0) begin
                chk("tx_frame_expected", {31'b0, tx_q.size() != 0}, 32'd1);
                sd = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
                frame = {1'b1, sd, 1'b0};
                for (int i = 0; i < 10; i++) begin
                    bad = 1'b0;
                    for (int j = 0; j < int'(DIV); j++) begin
                        if (i != 0 || j != 0) @(negedge clk);
                        if (uart_tx !== frame[i]) bad = 1'b1;
                    end
                    chk($sformatf("tx_bit%0d_seed%02h", i, sd), {31'b0, bad}, 32'd0);
                end
            end
        end
    end

    // Check each done pulse against the oldest expected outcome
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                chk("done_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("result",      {24'b0, result},      {24'b0, e.res});
                    chk("cycles",      cycles,               e.cyc);
                    chk("timeout_err", {31'b0, timeout_err}, {31'b0, e.to});
                    chk("frame_err",   {31'b0, frame_err},   {31'b0, e.fe});
                    chk("busy_at_done", {31'b0, busy},       32'd0);
                    @(negedge clk);
                    chk("done_single_cycle", {31'b0, done},  32'd0);
                    chk("result_held", {24'b0, result},      {24'b0, e.res});
                end
            end
        end
    end

    initial begin
        int mode;
        int d;
        int g;
        n_checks  = 0;
        n_pass    = 0;
        tx_mon_en = 1'b0;
        rst       = 1'b0;
        start     = 1'b0;
        seed      = 8'h00;
        uart_rx   = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_uart_tx",     {31'b0, uart_tx},     32'd1);
        chk("rst_busy",        {31'b0, busy},        32'd0);
        chk("rst_done",        {31'b0, done},        32'd0);
        chk("rst_result",      {24'b0, result},      32'd0);
        chk("rst_cycles",      cycles,               32'd0);
        chk("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        chk("rst_frame_err",   {31'b0, frame_err},   32'd0);
        tick(3);
        rst = 1'b0;
        tick(2);

        // Abort part-way through the seed frame
        pulse_start(8'hC3);
        tick(15);
        rst = 1'b1;
        #1;
        chk("abort_uart_tx", {31'b0, uart_tx}, 32'd1);
        chk("abort_busy",    {31'b0, busy},    32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("abort_line_idle", {31'b0, uart_tx}, 32'd1);
        tx_mon_en = 1'b1;

        run_txn(8'h01, M_NORMAL,  8'h5A, 20,  0);
        run_txn(8'hA5, M_NORMAL,  8'h3C, 100, 0);
        run_txn(8'h99, M_TIMEOUT, 8'h00, 0,   0);
        run_txn(8'h42, M_GLITCH,  8'h7E, 60,  10);
        run_txn(8'h17, M_FRAME,   8'hB6, 30,  0);

        for (int t = 0; t < 14; t++) begin
            mode = int'($urandom_range(0, 3));
            g    = int'($urandom_range(3, 20));
            if (mode == M_GLITCH) d = g + int'(HALF) + 5 + int'($urandom_range(0, 100));
            else                  d = int'($urandom_range(5, 300));
            run_txn(8'($urandom), mode, 8'($urandom), d, g);
        end

        tick(20);
        chk("no_pending_done", exp_q.size(), 32'd0);
        chk("no_pending_tx",   tx_q.size(),  32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
